// File: rtl/matrix_row_lsu.sv
`default_nettype none
// ============================================================================
// Module   : matrix_row_lsu
// Brief    : Moves matrix register rows between a multi-beat data bus and a
//            row-wide register-file port (row loads and row stores).
// Revision : 1.0
// ============================================================================

package xif_pkg;
    localparam int unsigned X_ID_WIDTH = 4;
endpackage

module matrix_row_lsu #(
    parameter int unsigned BUS_WIDTH = 128,
    parameter int unsigned RLEN      = 256,
    parameter int unsigned N_REGS    = 8,
    parameter int unsigned N_ROWS    = 4,
    parameter int unsigned ID_WIDTH  = xif_pkg::X_ID_WIDTH,
    localparam int unsigned RGW      = (N_REGS > 1) ? $clog2(N_REGS) : 1,
    localparam int unsigned RW       = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    output logic                   ready_o,
    input  logic                   write_i,
    input  logic [31:0]            address_i,
    input  logic [31:0]            stride_i,
    input  logic [RGW-1:0]         operand_reg_i,
    input  logic [ID_WIDTH-1:0]    instr_id_i,
    input  logic [31:0]            n_rows_i,
    input  logic [31:0]            n_bytes_cols_i,
    output logic                   data_req_o,
    input  logic                   data_gnt_i,
    output logic [31:0]            data_addr_o,
    output logic                   data_we_o,
    output logic [BUS_WIDTH/8-1:0] data_be_o,
    output logic [BUS_WIDTH-1:0]   data_wdata_o,
    input  logic                   data_rvalid_i,
    input  logic [BUS_WIDTH-1:0]   data_rdata_i,
    output logic [RGW-1:0]         waddr_o,
    output logic [RW-1:0]          wrowaddr_o,
    output logic [RLEN-1:0]        wdata_o,
    output logic                   we_o,
    output logic                   wlast_o,
    input  logic                   wready_i,
    output logic [RGW-1:0]         raddr_o,
    output logic [RW-1:0]          rrowaddr_o,
    input  logic [RLEN-1:0]        rdata_i,
    input  logic                   rdata_valid_i,
    output logic                   rdata_ready_o,
    output logic                   rlast_o,
    output logic                   finished_o,
    output logic [ID_WIDTH-1:0]    finished_instr_id_o,
    input  logic                   finished_ack_i
);

    localparam int unsigned BEATS = RLEN / BUS_WIDTH;
    localparam int unsigned BB    = BUS_WIDTH / 8;
    localparam int unsigned CW    = $clog2(BEATS) + 1;

    generate
        if (N_ROWS < 2) begin : g_bad_nrows
            $error("matrix_row_lsu: N_ROWS must be at least 2");
        end
        if ((BUS_WIDTH % 32 != 0) || (RLEN % BUS_WIDTH != 0) || (BEATS < 1) || (BEATS > 8)) begin : g_bad_widths
            $error("matrix_row_lsu: illegal BUS_WIDTH/RLEN combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_BUS = 3'd1,
        LD_WB  = 3'd2,
        ST_RD  = 3'd3,
        ST_BUS = 3'd4,
        DONE   = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [RW-1:0]       row_q, row_d;
    logic [CW-1:0]       iss_q, iss_d;
    logic [CW-1:0]       rsp_q, rsp_d;
    logic [CW-1:0]       out_q, out_d;
    logic [RLEN-1:0]     buf_q, buf_d;
    logic [31:0]         rowaddr_q, rowaddr_d;

    logic                write_q;
    logic [31:0]         stride_q;
    logic [RGW-1:0]      reg_q;
    logic [ID_WIDTH-1:0] id_q;
    logic [31:0]         nrows_q;
    logic [31:0]         ncols_q;

    logic [CW-1:0]       n_active_w;
    logic                row_active_w;
    logic                last_row_w;
    logic                bus_state_w;
    logic                req_w;
    logic                gnt_acc_w;
    logic                rsp_acc_w;
    logic                last_rsp_w;
    logic [BB-1:0]       be_iss_w;
    logic [BB-1:0]       be_rsp_w;
    logic [31:0]         beat_addr_w;

    // Byte j of beat b belongs to the row only if its row offset is below ncols.
    function automatic logic [BB-1:0] beat_be(input logic [CW-1:0] beat, input logic [31:0] ncols);
        logic [BB-1:0] be;
        for (int j = 0; j < BB; j++) begin
            be[j] = (32'(beat) * 32'(BB) + 32'(j)) < ncols;
        end
        return be;
    endfunction

    function automatic logic [BUS_WIDTH-1:0] mask_bytes(input logic [BUS_WIDTH-1:0] d, input logic [BB-1:0] be);
        logic [BUS_WIDTH-1:0] m;
        for (int j = 0; j < BB; j++) begin
            m[8*j +: 8] = be[j] ? d[8*j +: 8] : 8'h00;
        end
        return m;
    endfunction

    always_comb begin
        n_active_w = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (32'(b * BB) < ncols_q) begin
                n_active_w = n_active_w + CW'(1);
            end
        end
    end

    assign row_active_w = (32'(row_q) < nrows_q) && (n_active_w != '0);
    assign last_row_w   = (row_q == RW'(N_ROWS - 1));
    assign bus_state_w  = (state_q == LD_BUS) || (state_q == ST_BUS);
    assign req_w        = bus_state_w && row_active_w && (iss_q < n_active_w);
    assign gnt_acc_w    = req_w && data_gnt_i;
    // Responses only count against requests actually in flight; strays are dropped.
    assign rsp_acc_w    = bus_state_w && data_rvalid_i && (out_q != '0);
    assign last_rsp_w   = rsp_acc_w && ((rsp_q + CW'(1)) == n_active_w);
    assign be_iss_w     = beat_be(iss_q, ncols_q);
    assign be_rsp_w     = beat_be(rsp_q, ncols_q);
    assign beat_addr_w  = rowaddr_q + 32'(iss_q) * 32'(BB);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        iss_d     = iss_q;
        rsp_d     = rsp_q;
        buf_d     = buf_q;
        rowaddr_d = rowaddr_q;

        ready_o             = 1'b0;
        data_req_o          = req_w;
        data_addr_o         = '0;
        data_we_o           = 1'b0;
        data_be_o           = '0;
        data_wdata_o        = '0;
        waddr_o             = '0;
        wrowaddr_o          = '0;
        wdata_o             = '0;
        we_o                = 1'b0;
        wlast_o             = 1'b0;
        raddr_o             = '0;
        rrowaddr_o          = '0;
        rdata_ready_o       = 1'b0;
        rlast_o             = 1'b0;
        finished_o          = 1'b0;
        finished_instr_id_o = '0;

        if (req_w) begin
            data_addr_o = beat_addr_w;
            data_be_o   = be_iss_w;
            data_we_o   = write_q;
            if (write_q) begin
                data_wdata_o = buf_q[int'(iss_q)*BUS_WIDTH +: BUS_WIDTH];
            end
        end
        if (gnt_acc_w) begin
            iss_d = iss_q + CW'(1);
        end
        if (rsp_acc_w) begin
            rsp_d = rsp_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    state_d   = write_i ? ST_RD : LD_BUS;
                    row_d     = '0;
                    iss_d     = '0;
                    rsp_d     = '0;
                    buf_d     = '0;
                    rowaddr_d = address_i;
                end
            end
            LD_BUS: begin
                if (!row_active_w) begin
                    buf_d   = '0;
                    state_d = LD_WB;
                end else begin
                    if (rsp_acc_w) begin
                        buf_d[int'(rsp_q)*BUS_WIDTH +: BUS_WIDTH] = mask_bytes(data_rdata_i, be_rsp_w);
                    end
                    if (last_rsp_w) begin
                        iss_d   = '0;
                        rsp_d   = '0;
                        state_d = LD_WB;
                    end
                end
            end
            LD_WB: begin
                we_o       = 1'b1;
                waddr_o    = reg_q;
                wrowaddr_o = row_q;
                wdata_o    = buf_q;
                if (wready_i) begin
                    wlast_o = last_row_w;
                    buf_d   = '0;
                    if (last_row_w) begin
                        state_d = DONE;
                    end else begin
                        row_d     = row_q + RW'(1);
                        rowaddr_d = rowaddr_q + stride_q;
                        state_d   = LD_BUS;
                    end
                end
            end
            ST_RD: begin
                rdata_ready_o = 1'b1;
                raddr_o       = reg_q;
                rrowaddr_o    = row_q;
                if (rdata_valid_i) begin
                    rlast_o = last_row_w;
                    buf_d   = rdata_i;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // Rows beyond n_rows were still read out, they just never reach the bus.
                if (!row_active_w || last_rsp_w) begin
                    iss_d = '0;
                    rsp_d = '0;
                    if (last_row_w) begin
                        state_d = DONE;
                    end else begin
                        row_d     = row_q + RW'(1);
                        rowaddr_d = rowaddr_q + stride_q;
                        state_d   = ST_RD;
                    end
                end
            end
            DONE: begin
                finished_o          = 1'b1;
                finished_instr_id_o = id_q;
                if (finished_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case ({gnt_acc_w, rsp_acc_w})
            2'b10:   out_d = out_q + CW'(1);
            2'b01:   out_d = out_q - CW'(1);
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            row_q     <= '0;
            iss_q     <= '0;
            rsp_q     <= '0;
            out_q     <= '0;
            buf_q     <= '0;
            rowaddr_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            iss_q     <= iss_d;
            rsp_q     <= rsp_d;
            out_q     <= out_d;
            buf_q     <= buf_d;
            rowaddr_q <= rowaddr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            write_q  <= 1'b0;
            stride_q <= '0;
            reg_q    <= '0;
            id_q     <= '0;
            nrows_q  <= '0;
            ncols_q  <= '0;
        end else if (start_i && (state_q == IDLE)) begin
            write_q  <= write_i;
            stride_q <= stride_i;
            reg_q    <= operand_reg_i;
            id_q     <= instr_id_i;
            nrows_q  <= n_rows_i;
            ncols_q  <= n_bytes_cols_i;
        end
    end

endmodule

`default_nettype wire
